// File: rtl/flipflop_bank.sv
// Bank of WIDTH independent single-bit channels. At run time each channel
// behaves as a D, JK, T or SR flip-flop, with change pulses, an activity counter and error flags.
module flipflop_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sclr,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 mode_we,
  input  logic [2*WIDTH-1:0]   mode_wdata,
  output logic [WIDTH-1:0]     q,
  output logic [2*WIDTH-1:0]   mode,
  output logic [WIDTH-1:0]     changed,
  output logic [CNT_W-1:0]     act_cnt,
  output logic [WIDTH-1:0]     err
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_JK = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } ff_mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] err_set;
  logic             any_change;

  // NOTE: defaults are assigned before the case so every path drives q_next and err_set, which prevents latch inference.
  always_comb begin
    q_next  = q;
    err_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (ff_mode_e'(mode[2*i +: 2]))
        MODE_D:  q_next[i] = a[i];
        MODE_JK: begin
          unique case ({a[i], b[i]})
            2'b10:   q_next[i] = 1'b1;
            2'b01:   q_next[i] = 1'b0;
            2'b11:   q_next[i] = ~q[i];
            default: q_next[i] = q[i];
          endcase
        end
        MODE_T:  q_next[i] = q[i] ^ a[i];
        MODE_SR: begin
          unique case ({a[i], b[i]})
            2'b10:   q_next[i] = 1'b1;
            2'b01:   q_next[i] = 1'b0;
            2'b11:   err_set[i] = 1'b1;  // illegal S=R=1: q holds, the error is flagged
            default: q_next[i] = q[i];
          endcase
        end
        default: q_next[i] = q[i];
      endcase
    end
  end

  assign any_change = (q_next != q);

  // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= RESET_VAL;
      mode    <= '0;
      changed <= '0;
      act_cnt <= '0;
      err     <= '0;
    end else begin
      // The mode write lands with this edge, but q_next above was built from the old mode.
      if (mode_we) begin
        mode <= mode_wdata;
      end
      if (sclr) begin
        q       <= RESET_VAL;
        changed <= '0;
        act_cnt <= '0;
        err     <= '0;
      end else if (en) begin
        q       <= q_next;
        changed <= q_next ^ q;
        err     <= err | err_set;
        if (any_change && (act_cnt != CNT_MAX)) begin
          act_cnt <= act_cnt + 1'b1;
        end
      end else begin
        changed <= '0;
      end
    end
  end

endmodule

// File: tb/tb_flipflop_bank.sv
// Directed bench for flipflop_bank (WIDTH=8, RESET_VAL=8'hA5, CNT_W=2).
// Each check is an immediate assertion. The expected values are worked out by hand.
module tb_flipflop_bank;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               sclr;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               mode_we;
  logic [2*WIDTH-1:0] mode_wdata;
  logic [WIDTH-1:0]   q;
  logic [2*WIDTH-1:0] mode;
  logic [WIDTH-1:0]   changed;
  logic [CNT_W-1:0]   act_cnt;
  logic [WIDTH-1:0]   err;

  int total = 0;
  int bad   = 0;

  flipflop_bank #(
    .WIDTH    (WIDTH),
    .RESET_VAL(8'hA5),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sclr      (sclr),
    .a         (a),
    .b         (b),
    .mode_we   (mode_we),
    .mode_wdata(mode_wdata),
    .q         (q),
    .mode      (mode),
    .changed   (changed),
    .act_cnt   (act_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sclr = 1'b0; a = '0; b = '0;
    mode_we = 1'b0; mode_wdata = '0;

    // Asynchronous reset asserted between clock edges
    #12;
    reset = 1'b0;
    #1;
    check("rst_q",       64'(q),       64'hA5);
    check("rst_mode",    64'(mode),    64'h0);
    check("rst_act",     64'(act_cnt), 64'h0);
    check("rst_err",     64'(err),     64'h0);
    check("rst_changed", 64'(changed), 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("hold_q",       64'(q),       64'hA5);
    check("hold_changed", 64'(changed), 64'h0);

    // D mode
    en = 1'b1; a = 8'h3C;
    step();
    check("d_q",       64'(q),       64'h3C);
    check("d_changed", 64'(changed), 64'h99);
    check("d_act",     64'(act_cnt), 64'h1);
    step();
    check("d_rep_changed", 64'(changed), 64'h0);
    check("d_rep_act",     64'(act_cnt), 64'h1);
    a = 8'h00;
    step();
    check("d_zero_q",   64'(q),       64'h00);
    check("d_zero_act", 64'(act_cnt), 64'h2);

    // Switch all channels to JK, then run the sequence on channel 0
    en = 1'b0; mode_we = 1'b1; mode_wdata = 16'h5555;
    step();
    check("jk_mode", 64'(mode), 64'h5555);
    mode_we = 1'b0; en = 1'b1;
    a = 8'h01; b = 8'h00; step(); check("jk_set",    64'(q), 64'h01);
    check("jk_act", 64'(act_cnt), 64'h3);
    a = 8'h00; b = 8'h00; step(); check("jk_hold",   64'(q), 64'h01);
    a = 8'h01; b = 8'h01; step(); check("jk_tog1",   64'(q), 64'h00);
    a = 8'h01; b = 8'h01; step(); check("jk_tog2",   64'(q), 64'h01);
    a = 8'h00; b = 8'h01; step(); check("jk_clr",    64'(q), 64'h00);
    check("jk_act_sat", 64'(act_cnt), 64'h3);

    // Clear, then set ch0 to JK, ch1 to T, ch2 to SR and ch3..7 to JK
    sclr = 1'b1; a = '0; b = '0;
    step();
    check("sclr_q",   64'(q),       64'hA5);
    check("sclr_act", 64'(act_cnt), 64'h0);
    check("sclr_mode_kept", 64'(mode), 64'h5555);
    sclr = 1'b0; en = 1'b0; mode_we = 1'b1; mode_wdata = 16'h5579;
    step();
    mode_we = 1'b0; en = 1'b1;
    a = 8'h02;
    step(); check("t_q1", 64'(q), 64'hA7); check("t_chg1", 64'(changed), 64'h02);
    check("t_act1", 64'(act_cnt), 64'h1);
    step(); check("t_q2", 64'(q), 64'hA5);
    step(); check("t_q3", 64'(q), 64'hA7);
    step(); check("t_q4", 64'(q), 64'hA5); check("t_chg4", 64'(changed), 64'h02);
    check("t_act4", 64'(act_cnt), 64'h3);

    // SR on channel 2
    a = 8'h04; b = 8'h04;
    step();
    check("sr_ill_q",   64'(q),       64'hA5);
    check("sr_ill_err", 64'(err),     64'h04);
    check("sr_ill_chg", 64'(changed), 64'h00);
    a = 8'h00; b = 8'h00;
    step();
    check("sr_sticky", 64'(err), 64'h04);
    b = 8'h04;
    step();
    check("sr_clr_q",   64'(q),   64'hA1);
    check("sr_clr_err", 64'(err), 64'h04);
    sclr = 1'b1; b = 8'h00;
    step();
    check("sr_sclr_err", 64'(err), 64'h00);
    check("sr_sclr_q",   64'(q),   64'hA5);
    sclr = 1'b0;

    // Boundary: a mode write and data on the same edge, so the data still sees the old D mode
    en = 1'b0; mode_we = 1'b1; mode_wdata = 16'h5578;
    step();
    mode_we = 1'b0; en = 1'b1; a = 8'h00;
    step();
    check("mb_pre_q", 64'(q), 64'hA4);
    mode_we = 1'b1; mode_wdata = 16'h557A; a = 8'h01;
    step();
    check("mb_q_d",   64'(q),    64'hA5);
    check("mb_mode",  64'(mode), 64'h557A);
    mode_we = 1'b0;
    step();
    check("mb_q_t", 64'(q), 64'hA4);

    // Saturation of the 2-bit counter
    sclr = 1'b1;
    step();
    check("sat_start_act", 64'(act_cnt), 64'h0);
    sclr = 1'b0;
    step(); check("sat_act1", 64'(act_cnt), 64'h1);
    step(); check("sat_act2", 64'(act_cnt), 64'h2);
    step(); check("sat_act3", 64'(act_cnt), 64'h3);
    step(); check("sat_act4", 64'(act_cnt), 64'h3);
    step(); check("sat_act5", 64'(act_cnt), 64'h3);
    check("sat_q",   64'(q),       64'hA4);
    check("sat_chg", 64'(changed), 64'h01);

    // sclr takes priority over en and can land on the same edge as a mode write
    sclr = 1'b1; mode_we = 1'b1; mode_wdata = 16'h0000;
    step();
    check("pri_q",    64'(q),       64'hA5);
    check("pri_act",  64'(act_cnt), 64'h0);
    check("pri_chg",  64'(changed), 64'h00);
    check("pri_mode", 64'(mode),    64'h0000);

    // Reset across an edge overrides a pending mode write
    sclr = 1'b0; en = 1'b1; a = 8'hFF; mode_we = 1'b1; mode_wdata = 16'hFFFF;
    @(negedge clk);
    reset = 1'b0;
    step();
    check("rst2_mode", 64'(mode), 64'h0);
    check("rst2_q",    64'(q),    64'hA5);
    mode_we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    check("rst2_after_q", 64'(q), 64'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flipflop_bank.md
# flipflop_bank

Parametrised bank of WIDTH independent single-bit storage channels. Each channel is run-time configurable as a D, JK, T or SR flip-flop, generalising the single JK cell (JK next-state logic around a D flip-flop) into one registered block. The bank adds a global enable, a synchronous clear, per-channel change pulses, a saturating activity counter and a sticky illegal-SR error flag. It sits wherever the design previously instantiated discrete flip-flop cells: control latches, status bits and small handshake state.

## Interface
- WIDTH, 8: number of channels (1..64).
- RESET_VAL, {WIDTH{1'b0}}: value loaded into q by reset and by sclr.
- CNT_W, 8: width of the activity counter (2..32).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  global update enable; 0 = every channel holds.
- sclr  in  1  synchronous clear; has priority over en.
- a  in  WIDTH  per-channel primary input (D / J / T / S).
- b  in  WIDTH  per-channel secondary input (K / R); ignored in D and T modes.
- mode_we  in  1  mode register write strobe.
- mode_wdata  in  2*WIDTH  new modes; channel i uses bits [2i+1:2i].
- q  out  WIDTH  channel state.
- mode  out  2*WIDTH  current mode register.
- changed  out  WIDTH  registered one-cycle pulse per channel whose q changed on the last edge.
- act_cnt  out  CNT_W  count of edges on which any q bit changed; saturates.
- err  out  WIDTH  sticky per-channel flag, set by S=R=1 in SR mode.

## Operation
- Mode encoding per channel:
  - 00 D: q_next = a.
  - 01 JK: 00 hold, 10 set, 01 clear, 11 toggle (J=a, K=b).
  - 10 T: q_next = q ^ a.
  - 11 SR: 10 set, 01 clear, 00 hold. For 11, q holds and err[i] is set.
- Per-edge priority:
  - sclr=1: q<=RESET_VAL, err<=0, act_cnt<=0, changed<=0. mode is not cleared.
  - else en=1: every channel takes q_next per its current mode.
  - else: q, err and act_cnt hold, and changed<=0.
- changed <= q_next ^ q when en=1 and sclr=0, otherwise 0.
- act_cnt increments by 1 on an edge with en=1, sclr=0 and (q_next != q). It stops at 2^CNT_W-1 and does not wrap.
- err[i] is sticky. It is cleared only by sclr or reset, and it is set even when the channel's q does not change.
- mode_we=1: mode <= mode_wdata at the edge, independent of en and sclr.
  - Data on that same edge is evaluated with the old mode.
  - The new mode applies from the next edge.
- All arithmetic is unsigned. Channels are fully independent; no cross-channel logic except act_cnt.

## Timing
- Reset (reset=0, asynchronous, immediate): q=RESET_VAL, mode=0 (all channels D), changed=0, act_cnt=0, err=0.
- Reset deassertion is synchronised externally; the first active edge after release behaves normally.
- Latency: inputs sampled at edge n, so q, changed, act_cnt and err are valid after edge n. No combinational input-to-output path.
- Reset asserted mid-operation overrides any pending sclr, en or mode_we. A mode write on an edge coincident with reset is lost.
- sclr and mode_we on the same edge: both take effect (q cleared, mode updated).
- Toggling a channel every cycle in T or JK mode gives changed[i]=1 on every cycle and act_cnt +1 per cycle.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5. Drive reset low mid-cycle -> q=8'hA5, mode=0, act_cnt=0, err=0 with no clock edge; after release, q holds with en=0.
- D mode: en=1, a=8'h3C -> q=8'h3C and changed=8'h99 (from 8'hA5) one edge later, act_cnt=1. Repeat a=8'h3C -> changed=0, act_cnt unchanged.
- JK mode: write mode=16'h5555, then from q=0 apply (a,b)=(1,0),(0,0),(1,1),(1,1),(0,1) on channel 0 -> q[0]=1,1,0,1,0.
- T and SR: channel 1 mode 10 with a[1]=1 for 4 edges -> q[1] 1,0,1,0. Channel 2 mode 11 with S=R=1 -> q[2] holds, err[2]=1 and stays 1 after S=R=0, cleared by sclr.
- Mode-write boundary: q[0]=0, mode_we with mode 10 (T) and a[0]=1 on the same edge -> q[0]=1 (D applied). Next edge with a[0]=1 -> q[0]=0.
- Saturation and priority: CNT_W=2. Toggle for 5 edges -> act_cnt=3 and stays 3. Then sclr=1 with en=1 -> q=RESET_VAL, act_cnt=0, changed=0.
